// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit state encoding, frame bit indices
// and the frame parity helper. Also intended for the keyboard receiver.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INHIBIT   = 3'd1,
        RELEASE   = 3'd2,
        SHIFT     = 3'd3,
        ACK       = 3'd4,
        WAIT_IDLE = 3'd5,
        FIN       = 3'd6
    } ps2_tx_state_t;

    localparam logic [3:0] PS2_PARITY_IDX = 4'd8;
    localparam logic [3:0] PS2_STOP_IDX   = 4'd9;

    // PS/2 frames carry odd parity over the eight data bits.
    function automatic logic ps2_odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchroniser for one raw PS/2 pad plus a history flop that
// yields a one-cycle falling-edge pulse on the synchronised level.
module ps2_sync_edge (
    input  logic clk,
    input  logic resetn,
    input  logic pad,
    output logic level,
    output logic fall
);

    logic meta_r;
    logic sync_r;
    logic hist_r;

    // Pads idle high, so the chain resets to 1 to avoid a false edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            meta_r <= 1'b1;
            sync_r <= 1'b1;
            hist_r <= 1'b1;
        end else begin
            meta_r <= pad;
            sync_r <= meta_r;
            hist_r <= sync_r;
        end
    end

    assign level = sync_r;
    assign fall  = hist_r & ~sync_r;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter with device ACK check.
// Optional transfer watchdog is built when PS2_TX_TIMEOUT_EN is defined.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       done,
    output logic       err
);

    localparam int INH_W = (INHIBIT_CYCLES > 2) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [INH_W-1:0] INH_PRE  = INH_W'(INHIBIT_CYCLES - 2);

    ps2_tx_state_t    state_r;
    ps2_tx_state_t    state_s;
    logic [7:0]       byte_r;
    logic [7:0]       byte_s;
    logic             par_r;
    logic             par_s;
    logic [3:0]       bcnt_r;
    logic [3:0]       bcnt_s;
    logic [INH_W-1:0] inh_cnt_r;
    logic [INH_W-1:0] inh_cnt_s;
    logic             clk_oe_r;
    logic             clk_oe_s;
    logic             data_oe_r;
    logic             data_oe_s;
    logic             tx_ready_r;
    logic             tx_ready_s;
    logic             done_r;
    logic             done_s;
    logic             err_r;
    logic             err_s;

    logic             accept_s;
    logic             abort_s;
    logic             clk_lvl_s;
    logic             clk_fall_s;
    logic             data_lvl_s;
    logic             data_fall_unused_s;

    ps2_sync_edge u_clk_sync (
        .clk    (clk),
        .resetn (resetn),
        .pad    (ps2_clk),
        .level  (clk_lvl_s),
        .fall   (clk_fall_s)
    );

    ps2_sync_edge u_data_sync (
        .clk    (clk),
        .resetn (resetn),
        .pad    (ps2_data),
        .level  (data_lvl_s),
        .fall   (data_fall_unused_s)
    );

    assign accept_s = tx_valid & tx_ready_r;

`ifdef PS2_TX_TIMEOUT_EN
    localparam int CYC_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(TIMEOUT_CYCLES - 1);

    logic [CYC_W-1:0] cyc_cnt_r;
    logic             timeout_s;

    // Watchdog: restarts at accept and saturates at the timeout limit.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cyc_cnt_r <= {CYC_W{1'b0}};
        end else if (accept_s) begin
            cyc_cnt_r <= {CYC_W{1'b0}};
        end else if (cyc_cnt_r != CYC_LAST) begin
            cyc_cnt_r <= cyc_cnt_r + CYC_W'(1);
        end else begin
            cyc_cnt_r <= cyc_cnt_r;
        end
    end

    assign timeout_s = (cyc_cnt_r == CYC_LAST);
    // The inhibit phase is host-timed, so only device-paced states can expire.
    assign abort_s   = timeout_s &&
                       (state_r inside {RELEASE, SHIFT, ACK, WAIT_IDLE});
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

    assign abort_s = 1'b0;
`endif

    // Next state, next registered outputs and frame datapath.
    always_comb begin
        state_s   = state_r;
        byte_s    = byte_r;
        par_s     = par_r;
        bcnt_s    = bcnt_r;
        inh_cnt_s = inh_cnt_r;
        clk_oe_s  = 1'b0;
        data_oe_s = data_oe_r;
        err_s     = err_r;
        done_s    = 1'b0;
        if (abort_s) begin
            state_s   = FIN;
            data_oe_s = 1'b0;
            err_s     = 1'b1;
            done_s    = 1'b1;
        end else begin
            case (state_r)
                IDLE, FIN: begin
                    data_oe_s = 1'b0;
                    if (accept_s) begin
                        state_s   = INHIBIT;
                        byte_s    = tx_data;
                        par_s     = ps2_odd_parity(tx_data);
                        bcnt_s    = 4'd0;
                        inh_cnt_s = {INH_W{1'b0}};
                        clk_oe_s  = 1'b1;
                        err_s     = 1'b0;
                    end else begin
                        state_s = IDLE;
                    end
                end
                INHIBIT: begin
                    if (inh_cnt_r == INH_LAST) begin
                        state_s   = RELEASE;
                        data_oe_s = 1'b1;
                    end else begin
                        clk_oe_s  = 1'b1;
                        inh_cnt_s = inh_cnt_r + INH_W'(1);
                        // Start bit goes out in the final inhibit cycle.
                        data_oe_s = (inh_cnt_r == INH_PRE);
                    end
                end
                RELEASE: begin
                    data_oe_s = 1'b1;
                    state_s   = SHIFT;
                end
                SHIFT: begin
                    if (clk_fall_s) begin
                        if (bcnt_r < PS2_PARITY_IDX) begin
                            data_oe_s = ~byte_r[bcnt_r[2:0]];
                        end else if (bcnt_r == PS2_PARITY_IDX) begin
                            data_oe_s = ~par_r;
                        end else begin
                            data_oe_s = 1'b0;
                        end
                        bcnt_s = bcnt_r + 4'd1;
                        if (bcnt_r == PS2_STOP_IDX) begin
                            state_s = ACK;
                        end else begin
                            state_s = SHIFT;
                        end
                    end else begin
                        state_s = SHIFT;
                    end
                end
                ACK: begin
                    data_oe_s = 1'b0;
                    if (clk_fall_s) begin
                        err_s   = data_lvl_s;
                        state_s = WAIT_IDLE;
                    end else begin
                        state_s = ACK;
                    end
                end
                WAIT_IDLE: begin
                    data_oe_s = 1'b0;
                    if (clk_lvl_s && data_lvl_s) begin
                        state_s = FIN;
                        done_s  = 1'b1;
                    end else begin
                        state_s = WAIT_IDLE;
                    end
                end
                default: begin
                    state_s   = IDLE;
                    data_oe_s = 1'b0;
                end
            endcase
        end
        tx_ready_s = (state_s == IDLE) || (state_s == FIN);
    end

    // State, datapath and output registers; reset releases both pads at once.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r    <= IDLE;
            byte_r     <= 8'h00;
            par_r      <= 1'b0;
            bcnt_r     <= 4'd0;
            inh_cnt_r  <= {INH_W{1'b0}};
            clk_oe_r   <= 1'b0;
            data_oe_r  <= 1'b0;
            tx_ready_r <= 1'b1;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            state_r    <= state_s;
            byte_r     <= byte_s;
            par_r      <= par_s;
            bcnt_r     <= bcnt_s;
            inh_cnt_r  <= inh_cnt_s;
            clk_oe_r   <= clk_oe_s;
            data_oe_r  <= data_oe_s;
            tx_ready_r <= tx_ready_s;
            done_r     <= done_s;
            err_r      <= err_s;
        end
    end

    assign ps2_clk_oe  = clk_oe_r;
    assign ps2_data_oe = data_oe_r;
    assign tx_ready    = tx_ready_r;
    assign done        = done_r;
    assign err         = err_r;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: a behavioural PS/2 device clocks the
// frame out, records the data seen at each clock rise and answers ACK/NACK.
module tb_ps2_host_tx;

    localparam int INH  = 20;
    localparam int TMO  = 2000;
    localparam int HALF = 25;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       ps2_clk;
    logic       ps2_data;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       tx_ready;
    logic       done;
    logic       err;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    assign ps2_clk  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    // Expected frame as seen at the device's clock rises: start, LSB-first data, odd parity, stop.
    function automatic logic [10:0] frame_of(input logic [7:0] b);
        logic [10:0] f;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = b[i];
        f[9]  = (($countones(b) % 2) == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Request one byte and play the device side; abort_at>0 stops after that many clock rises.
    task automatic run_frame(input logic [7:0] b, input logic nack, input bit inject,
                             input int abort_at, output bit acc_ok, output int inh_len,
                             output logic start_drv, output logic [10:0] seen,
                             output bit got_done, output logic done_err,
                             output int done_delta, output bit idle_ok);
        int base;
        acc_ok = 1'b0; inh_len = 0; start_drv = 1'b0; seen = 11'h000;
        got_done = 1'b0; done_err = 1'bx; done_delta = 0; idle_ok = 1'b0;
        base = done_cnt;
        @(negedge clk); tx_valid = 1'b1; tx_data = b;
        @(posedge clk); #1; tx_valid = 1'b0;
        acc_ok = (tx_ready === 1'b0) && (ps2_clk_oe === 1'b1);
        inh_len = 1;
        while (ps2_clk_oe === 1'b1 && inh_len < 10 * INH) begin
            start_drv = ps2_data_oe;
            @(posedge clk); #1;
            if (ps2_clk_oe === 1'b1) inh_len++;
        end
        if (inject) begin
            @(negedge clk); tx_valid = 1'b1; tx_data = 8'h55;
            repeat (3) @(negedge clk);
            tx_valid = 1'b0;
        end
        wait_cyc(HALF);
        seen[0] = ps2_data;
        for (int k = 1; k <= 10; k++) begin
            dev_clk_low = 1'b1;
            wait_cyc(HALF);
            dev_clk_low = 1'b0;
            wait_cyc(HALF);
            seen[k] = ps2_data;
            if (k == abort_at) return;
        end
        dev_data_low = ~nack;
        wait_cyc(HALF);
        dev_clk_low = 1'b1;
        wait_cyc(HALF);
        dev_clk_low = 1'b0;
        dev_data_low = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                got_done = (tx_ready === 1'b1);
                done_err = err;
                break;
            end
        end
        wait_cyc(40);
        done_delta = done_cnt - base;
        idle_ok = (ps2_clk_oe === 1'b0) && (ps2_data_oe === 1'b0) && (tx_ready === 1'b1);
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (ps2_clk_oe !== 1'b0) begin errors++; $display("FAIL reset_clk_oe: got %b want 0", ps2_clk_oe); end
        checks++; if (ps2_data_oe !== 1'b0) begin errors++; $display("FAIL reset_data_oe: got %b want 0", ps2_data_oe); end
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_tx_ready: got %b want 1", tx_ready); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
        @(negedge clk); resetn = 1'b1;
        wait_cyc(5);
        checks++; if (tx_ready !== 1'b1 || ps2_clk_oe !== 1'b0) begin
            errors++; $display("FAIL post_reset_idle: tx_ready=%b clk_oe=%b want 1/0", tx_ready, ps2_clk_oe);
        end
    endtask

    task automatic test_frames;
        logic [7:0] bytes [4] = '{8'hED, 8'h01, 8'hFF, 8'hF4};
        logic       nacks [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        bit acc_ok, got_done, idle_ok; int inh_len, delta; logic start_drv, derr; logic [10:0] seen;
        for (int i = 0; i < 4; i++) begin
            run_frame(bytes[i], nacks[i], 1'b0, -1, acc_ok, inh_len, start_drv, seen, got_done, derr, delta, idle_ok);
            checks++; if (!acc_ok) begin errors++; $display("FAIL accept_%02h: tx_ready/clk_oe after accept wrong, want 0/1", bytes[i]); end
            checks++; if (inh_len != INH) begin errors++; $display("FAIL inhibit_%02h: got %0d cycles want %0d", bytes[i], inh_len, INH); end
            checks++; if (start_drv !== 1'b1) begin errors++; $display("FAIL start_bit_%02h: data_oe in last inhibit cycle %b want 1", bytes[i], start_drv); end
            checks++; if (seen !== frame_of(bytes[i])) begin errors++; $display("FAIL frame_%02h: got %b want %b", bytes[i], seen, frame_of(bytes[i])); end
            checks++; if (!got_done) begin errors++; $display("FAIL done_%02h: got none want done with tx_ready 1", bytes[i]); end
            checks++; if (derr !== nacks[i]) begin errors++; $display("FAIL err_%02h: got %b want %b", bytes[i], derr, nacks[i]); end
            checks++; if (delta != 1) begin errors++; $display("FAIL done_count_%02h: got %0d want 1", bytes[i], delta); end
            checks++; if (!idle_ok) begin errors++; $display("FAIL idle_after_%02h: lines not released or not ready", bytes[i]); end
        end
    endtask

    task automatic test_random;
        bit acc_ok, got_done, idle_ok; int inh_len, delta; logic start_drv, derr; logic [10:0] seen;
        logic [7:0] b; logic nack;
        for (int i = 0; i < 6; i++) begin
            b    = 8'($urandom_range(255, 0));
            nack = 1'($urandom_range(1, 0));
            run_frame(b, nack, 1'b0, -1, acc_ok, inh_len, start_drv, seen, got_done, derr, delta, idle_ok);
            checks++; if (seen !== frame_of(b)) begin errors++; $display("FAIL rand_frame_%02h: got %b want %b", b, seen, frame_of(b)); end
            checks++; if (!got_done || derr !== nack) begin errors++; $display("FAIL rand_done_%02h: done=%b err=%b want 1/%b", b, got_done, derr, nack); end
            checks++; if (delta != 1) begin errors++; $display("FAIL rand_done_count_%02h: got %0d want 1", b, delta); end
            checks++; if (!idle_ok) begin errors++; $display("FAIL rand_idle_%02h: lines not released or not ready", b); end
        end
    endtask

    task automatic test_reset_mid;
        bit acc_ok, got_done, idle_ok; int inh_len, delta; logic start_drv, derr; logic [10:0] seen;
        logic [10:0] exp;
        exp = frame_of(8'hED);
        run_frame(8'hED, 1'b0, 1'b0, 4, acc_ok, inh_len, start_drv, seen, got_done, derr, delta, idle_ok);
        checks++; if (seen[4:0] !== exp[4:0]) begin errors++; $display("FAIL mid_partial: got %b want %b", seen[4:0], exp[4:0]); end
        checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL mid_busy: tx_ready %b want 0", tx_ready); end
        #3 resetn = 1'b0;
        #1;
        checks++; if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin
            errors++; $display("FAIL mid_reset_release: clk_oe=%b data_oe=%b want 0/0", ps2_clk_oe, ps2_data_oe);
        end
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_ready: got %b want 1", tx_ready); end
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        wait_cyc(5);
        run_frame(8'hED, 1'b0, 1'b0, -1, acc_ok, inh_len, start_drv, seen, got_done, derr, delta, idle_ok);
        checks++; if (seen !== exp) begin errors++; $display("FAIL after_reset_frame: got %b want %b", seen, exp); end
        checks++; if (!got_done || derr !== 1'b0) begin errors++; $display("FAIL after_reset_done: done=%b err=%b want 1/0", got_done, derr); end
        checks++; if (delta != 1) begin errors++; $display("FAIL after_reset_count: got %0d want 1", delta); end
    endtask

    task automatic test_ignore_busy;
        bit acc_ok, got_done, idle_ok; int inh_len, delta, base; logic start_drv, derr; logic [10:0] seen;
        base = done_cnt;
        run_frame(8'hED, 1'b0, 1'b1, -1, acc_ok, inh_len, start_drv, seen, got_done, derr, delta, idle_ok);
        checks++; if (seen !== frame_of(8'hED)) begin errors++; $display("FAIL busy_frame: got %b want %b", seen, frame_of(8'hED)); end
        checks++; if (!got_done || derr !== 1'b0) begin errors++; $display("FAIL busy_done: done=%b err=%b want 1/0", got_done, derr); end
        wait_cyc(60);
        checks++; if (done_cnt - base != 1) begin errors++; $display("FAIL busy_one_done: got %0d want 1", done_cnt - base); end
        checks++; if (ps2_clk_oe !== 1'b0 || tx_ready !== 1'b1) begin
            errors++; $display("FAIL busy_no_second_frame: clk_oe=%b tx_ready=%b want 0/1", ps2_clk_oe, tx_ready);
        end
    endtask

`ifdef PS2_TX_TIMEOUT_EN
    task automatic test_timeout;
        int k;
        @(negedge clk); tx_valid = 1'b1; tx_data = 8'hED;
        @(posedge clk); #1; tx_valid = 1'b0;
        k = 0;
        while (done !== 1'b1 && k < 3 * TMO) begin
            @(posedge clk); #1;
            k++;
        end
        checks++; if (k != TMO) begin errors++; $display("FAIL timeout_cycle: done at %0d want %0d", k, TMO); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL timeout_err: got %b want 1", err); end
        checks++; if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin
            errors++; $display("FAIL timeout_release: clk_oe=%b data_oe=%b want 0/0", ps2_clk_oe, ps2_data_oe);
        end
        wait_cyc(10);
    endtask
`endif

    initial begin
        test_reset();
        test_frames();
        test_random();
        test_reset_mid();
        test_ignore_busy();
`ifdef PS2_TX_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
